// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches {opcode, rpt} words from program memory and
// issues each opcode rpt+1 times, inserting multiply wait cycles and flagging reserved opcodes.
module instr_sequencer #(
    parameter int OP_WIDTH   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] prog_len,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [OP_WIDTH+3:0]   imem_data,
    output logic [OP_WIDTH-1:0]   opcode_out,
    output logic                  issue,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal_op
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_LAST = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_NOP  = '1;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_pc, r_len;
    logic [OP_WIDTH-1:0]   r_op;
    logic [3:0]            r_cnt;
    logic [3:0]            r_wait;
    logic                  r_last, r_first, r_illegal;

    logic [OP_WIDTH-1:0]   w_op;
    logic [3:0]            w_remain;
    logic                  w_is_mul, w_reserved, w_legal, w_end_pc;

    // First ISSUE cycle takes the word straight from memory; repeats use the captured copy.
    assign w_op       = r_first ? imem_data[OP_WIDTH+3:4] : r_op;
    assign w_remain   = r_first ? imem_data[3:0] : r_cnt;
    assign w_is_mul   = (w_op == OP_MUL) && (MUL_LAT > 1);
    assign w_legal    = (w_op <= OP_LAST);
    assign w_reserved = !w_legal && (w_op != OP_NOP);
    assign w_end_pc   = (r_pc == r_len - ADDR_WIDTH'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = (prog_len == '0) ? DONE : FETCH;
            FETCH: w_next = ISSUE;
            ISSUE: begin
                if (w_is_mul)            w_next = WAIT;
                else if (w_remain != '0) w_next = ISSUE;
                else                     w_next = w_end_pc ? DONE : FETCH;
            end
            WAIT: begin
                if (r_wait == '0) begin
                    if (!r_last) w_next = ISSUE;
                    else         w_next = w_end_pc ? DONE : FETCH;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_len     <= '0;
            r_op      <= OP_NOP;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_last    <= 1'b0;
            r_first   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len     <= prog_len;
                        r_pc      <= '0;
                        r_illegal <= 1'b0;
                    end
                end
                FETCH: r_first <= 1'b1;
                ISSUE: begin
                    r_first <= 1'b0;
                    r_op    <= w_op;
                    r_cnt   <= w_remain - 4'd1;
                    r_last  <= (w_remain == '0);
                    r_wait  <= 4'(MUL_LAT - 2);
                    if (w_reserved) r_illegal <= 1'b1;
                end
                WAIT:    r_wait <= r_wait - 4'd1;
                default: ;
            endcase
            if ((r_state == ISSUE || r_state == WAIT) && w_next == FETCH)
                r_pc <= r_pc + ADDR_WIDTH'(1);
        end
    end

    assign imem_addr  = r_pc;
    assign issue      = (r_state == ISSUE) && w_legal;
    assign opcode_out = issue ? w_op : OP_NOP;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign illegal_op = r_illegal || ((r_state == ISSUE) && w_reserved);

endmodule
